// File: rtl/serial_link_pkg.sv
// rtl/serial_link_pkg.sv - shared serial link state encoding and line constants
//
// Purpose : definitions shared by the serial link transmitter and receiver:
//           FSM state enum and the on-wire conventions (bit order, parity sense).
// Ports   : none (package).
// Macro   : SERIAL_LINK_TX_PARITY_EN adds the PARITY state to the enum.
package serial_link_pkg;

    // Words go out most-significant bit first.
    localparam bit LINK_MSB_FIRST   = 1'b1;
    // Parity bit makes the total number of ones (data + parity) even.
    localparam bit LINK_PARITY_EVEN = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1
`ifdef SERIAL_LINK_TX_PARITY_EN
        ,
        ST_PARITY = 2'd2
`endif
    } link_state_e;

endpackage

// File: rtl/serial_link_tx_if.sv
// rtl/serial_link_tx_if.sv - word input and bit-serial output bundle of the link transmitter
//
// Purpose : groups the word-side val/rdy handshake and the serial-side
//           val/rdy/sof/eof line into one interface.
// Ports   : recv_msg/recv_val/recv_rdy - word handshake into the transmitter
//           ser_data/ser_val/ser_rdy   - per-bit handshake out of the transmitter
//           ser_sof/ser_eof            - frame boundary markers on the serial line
// Modports: master - the side feeding words and accepting bits
//           slave  - the transmitter itself
interface serial_link_tx_if #(
    parameter int BIT_WIDTH = 32
);
    logic [BIT_WIDTH-1:0] recv_msg;
    logic                 recv_val;
    logic                 recv_rdy;
    logic                 ser_data;
    logic                 ser_val;
    logic                 ser_rdy;
    logic                 ser_sof;
    logic                 ser_eof;

    modport master (
        output recv_msg, recv_val, ser_rdy,
        input  recv_rdy, ser_data, ser_val, ser_sof, ser_eof
    );

    modport slave (
        input  recv_msg, recv_val, ser_rdy,
        output recv_rdy, ser_data, ser_val, ser_sof, ser_eof
    );
endinterface

// File: rtl/serial_link_tx.sv
// rtl/serial_link_tx.sv - bit-serial link transmitter with frame markers
//
// Purpose : takes BIT_WIDTH-bit words over val/rdy and shifts them out one bit
//           per accepted serial beat, flagging the first bit of each
//           N_SAMPLES-word frame (ser_sof) and its final bit (ser_eof).
// Ports   : clk   - clock
//           reset - asynchronous, active-high reset
//           link  - serial_link_tx_if.slave (recv_* word side, ser_* bit side)
// Macro   : SERIAL_LINK_TX_PARITY_EN appends one even-parity bit per word;
//           ser_eof then marks the parity bit of the last word of a frame.
module serial_link_tx
    import serial_link_pkg::*;
#(
    parameter int BIT_WIDTH = 32,
    parameter int N_SAMPLES = 8
) (
    input  logic             clk,
    input  logic             reset,
    serial_link_tx_if.slave  link
);

    localparam int BC_W = $clog2(BIT_WIDTH);
    localparam int WC_W = $clog2(N_SAMPLES);
    localparam logic [BC_W-1:0] BIT_LAST  = BC_W'(BIT_WIDTH - 1);
    localparam logic [WC_W-1:0] WORD_LAST = WC_W'(N_SAMPLES - 1);

    link_state_e          state_q, state_d;
    logic [BIT_WIDTH-1:0] shift_q, shift_d;
    logic [BC_W-1:0]      bit_cnt_q, bit_cnt_d;
    logic [WC_W-1:0]      word_cnt_q, word_cnt_d;
`ifdef SERIAL_LINK_TX_PARITY_EN
    logic                 parity_q, parity_d;
`endif

    logic recv_rdy_q, recv_rdy_d;
    logic ser_val_q,  ser_val_d;
    logic ser_data_q, ser_data_d;
    logic ser_sof_q,  ser_sof_d;
    logic ser_eof_q,  ser_eof_d;

    logic accept;
    logic bit_taken;
    logic word_done;

    always_comb begin
        accept     = link.recv_val & recv_rdy_q;
        bit_taken  = ser_val_q & link.ser_rdy;
        state_d    = state_q;
        shift_d    = shift_q;
        bit_cnt_d  = bit_cnt_q;
        word_cnt_d = word_cnt_q;
        word_done  = 1'b0;
`ifdef SERIAL_LINK_TX_PARITY_EN
        parity_d   = parity_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d   = ST_SHIFT;
                    shift_d   = link.recv_msg;
                    bit_cnt_d = '0;
`ifdef SERIAL_LINK_TX_PARITY_EN
                    parity_d  = (^link.recv_msg) ^ ~LINK_PARITY_EVEN;
`endif
                end
            end
            ST_SHIFT: begin
                if (bit_taken) begin
                    shift_d   = LINK_MSB_FIRST ? {shift_q[BIT_WIDTH-2:0], 1'b0}
                                               : {1'b0, shift_q[BIT_WIDTH-1:1]};
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (bit_cnt_q == BIT_LAST) begin
`ifdef SERIAL_LINK_TX_PARITY_EN
                        state_d   = ST_PARITY;
`else
                        state_d   = ST_IDLE;
                        word_done = 1'b1;
`endif
                    end
                end
            end
`ifdef SERIAL_LINK_TX_PARITY_EN
            ST_PARITY: begin
                if (bit_taken) begin
                    state_d   = ST_IDLE;
                    word_done = 1'b1;
                end
            end
`endif
            default: state_d = ST_IDLE;
        endcase

        if (word_done) begin
            word_cnt_d = (word_cnt_q == WORD_LAST) ? '0 : word_cnt_q + 1'b1;
        end

        // Outputs are registered from the next state so they change only on a
        // clock edge and never see ser_rdy combinationally.
        recv_rdy_d = (state_d == ST_IDLE);
        ser_val_d  = (state_d != ST_IDLE);
        ser_data_d = 1'b0;
        if (state_d == ST_SHIFT) begin
            ser_data_d = LINK_MSB_FIRST ? shift_d[BIT_WIDTH-1] : shift_d[0];
        end
`ifdef SERIAL_LINK_TX_PARITY_EN
        if (state_d == ST_PARITY) begin
            ser_data_d = parity_d;
        end
`endif
        ser_sof_d = (state_d == ST_SHIFT) && (bit_cnt_d == '0) && (word_cnt_d == '0);
`ifdef SERIAL_LINK_TX_PARITY_EN
        ser_eof_d = (state_d == ST_PARITY) && (word_cnt_d == WORD_LAST);
`else
        ser_eof_d = (state_d == ST_SHIFT) && (bit_cnt_d == BIT_LAST)
                    && (word_cnt_d == WORD_LAST);
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            shift_q    <= '0;
            bit_cnt_q  <= '0;
            word_cnt_q <= '0;
`ifdef SERIAL_LINK_TX_PARITY_EN
            parity_q   <= 1'b0;
`endif
            recv_rdy_q <= 1'b1;
            ser_val_q  <= 1'b0;
            ser_data_q <= 1'b0;
            ser_sof_q  <= 1'b0;
            ser_eof_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            bit_cnt_q  <= bit_cnt_d;
            word_cnt_q <= word_cnt_d;
`ifdef SERIAL_LINK_TX_PARITY_EN
            parity_q   <= parity_d;
`endif
            recv_rdy_q <= recv_rdy_d;
            ser_val_q  <= ser_val_d;
            ser_data_q <= ser_data_d;
            ser_sof_q  <= ser_sof_d;
            ser_eof_q  <= ser_eof_d;
        end
    end

    assign link.recv_rdy = recv_rdy_q;
    assign link.ser_val  = ser_val_q;
    assign link.ser_data = ser_data_q;
    assign link.ser_sof  = ser_sof_q;
    assign link.ser_eof  = ser_eof_q;

endmodule

// File: doc/serial_link_tx.md
# serial_link_tx

Bit-serial link transmitter for the sample/result word stream. Accepts one `BIT_WIDTH`-bit word at a time over a val/rdy interface and shifts it out MSB-first on a 1-bit data line, with per-bit val/rdy flow control. It marks frame boundaries of `N_SAMPLES` words so the off-chip or peer receiver can rebuild FFT frames. It sits between the serializer output of the FFT harness and the chip pins, and is the transmitting end of the serial link whose receiver feeds the deserializer.

## Interface
- `BIT_WIDTH`, 32, word width in bits; must be ≥ 2.
- `N_SAMPLES`, 8, words per frame; must be ≥ 2.

- `clk`  in  1  clock.
- `reset`  in  1  asynchronous, active-high reset.
- `recv_msg`  in  BIT_WIDTH  word to transmit.
- `recv_val`  in  1  `recv_msg` valid.
- `recv_rdy`  out  1  block can accept a word.
- `ser_data`  out  1  current serial bit.
- `ser_val`  out  1  `ser_data` valid.
- `ser_rdy`  in  1  receiver accepts the bit this cycle.
- `ser_sof`  out  1  current bit is bit 0 (MSB) of word 0 of a frame.
- `ser_eof`  out  1  current bit is the final bit of word `N_SAMPLES-1`.

## Operation
- States:
  - IDLE: `recv_rdy`=1, `ser_val`=0.
  - SHIFT: `ser_val`=1, `ser_data` = shift register MSB.
  - PARITY: exists only with the macro enabled; `ser_val`=1, `ser_data` = stored parity bit.
- IDLE → SHIFT on `recv_val & recv_rdy`:
  - load shift register with `recv_msg`;
  - clear `bit_cnt`;
  - with the macro enabled, store the even-parity bit, i.e. XOR-reduce of `recv_msg`.
- SHIFT, on `ser_val & ser_rdy`:
  - shift left 1 and increment `bit_cnt`;
  - if `bit_cnt == BIT_WIDTH-1`, the word is done; go to PARITY if enabled, else IDLE.
- PARITY, on `ser_val & ser_rdy`: word done, go to IDLE.
- Word done:
  - `word_cnt` increments;
  - `word_cnt` wraps from `N_SAMPLES-1` to 0.
- Counter widths:
  - `bit_cnt` is `$clog2(BIT_WIDTH)` bits.
  - `word_cnt` is `$clog2(N_SAMPLES)` bits.
- `ser_sof` = SHIFT & `bit_cnt`==0 & `word_cnt`==0.
- `ser_eof` = `word_cnt`==`N_SAMPLES-1` & final bit of that word:
  - macro disabled: SHIFT & `bit_cnt`==`BIT_WIDTH-1`;
  - macro enabled: PARITY.
- Outputs are Moore outputs of registered state. There is no combinational path from `ser_rdy` to any output.
- Data, sof and eof hold stable while `ser_val=1` and `ser_rdy=0`.

## Timing
- Reset, asynchronous, takes effect immediately:
  - state = IDLE;
  - `bit_cnt`, `word_cnt`, shift register and parity = 0;
  - `recv_rdy`=1; `ser_val`, `ser_data`, `ser_sof`, `ser_eof` = 0.
- Latency: a word accepted at edge k presents its MSB on `ser_data` in cycle k+1.
- Throughput with `ser_rdy` held at 1:
  - `BIT_WIDTH+1` cycles per word without parity (one IDLE bubble);
  - `BIT_WIDTH+2` cycles per word with parity.
- `recv_rdy` is low for the whole transmission of a word, including stalls.
- `recv_val` while not ready is ignored; the word is not captured.
- Reset mid-word or mid-frame:
  - the partial word is discarded and `word_cnt` returns to 0;
  - the next accepted word starts a new frame with `ser_sof`.
- `ser_rdy` while `ser_val`=0 has no effect.

## Configuration
- `SERIAL_LINK_TX_PARITY_EN`, defined:
  - PARITY state present;
  - each word is followed by one even-parity bit;
  - `ser_eof` is flagged on the parity bit of the last word.
- Undefined:
  - no PARITY state or parity register;
  - words are exactly `BIT_WIDTH` bits.

## Structure
- Shared package `serial_link_pkg`:
  - state enum (IDLE, SHIFT, PARITY);
  - link constants shared with the receiver: bit order MSB-first and parity polarity (even).
- Single module, no sub-module. The parity reduction and counters are inline.

## Test plan
All scenarios use BIT_WIDTH=32 and N_SAMPLES=8.
- Reset check: assert `reset` asynchronously mid-cycle → all outputs 0 except `recv_rdy`=1, immediately.
- Single word: send 0x80000001 with `ser_rdy`=1 →
  - bits are 1, then 30 zeros, then 1, on consecutive cycles;
  - `ser_sof` high on the first bit only;
  - `recv_rdy` low 32 cycles, then high.
- Backpressure: word 0xA5A5A5A5, drop `ser_rdy` for 5 cycles after bit 10 → `ser_data`, `ser_val` and `ser_sof` frozen; 32 bits total, sequence unchanged.
- Frame framing: 9 words 0x0..0x8 → `ser_sof` on the MSB of words 0 and 8; `ser_eof` only on the LSB of word 7.
- Parity (macro on):
  - 0x00000007 → 33rd bit = 1;
  - 0x00000003 → 33rd bit = 0;
  - `ser_eof` on the parity bit of word 7.
- Reset mid-word: reset after 10 bits of word 3 → outputs cleared; next word carries `ser_sof` on its first bit.
